keypress_queue: RTL and testbench

KEYPRESS_QUEUE -- requirements
Module: keypress_queue

---
 rtl/wam_pkg.sv | 16 +
 rtl/keypress_queue_if.sv | 12 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/keypress_queue.sv | 125 ++++++++++++
 tb/tb_keypress_queue.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wam_pkg.sv
// Shared keypad constants and key-code helpers.
package wam_pkg;

  localparam int KEY_W     = 4;
  localparam int COORD_MAX = 2;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_fields_t;

  function automatic key_fields_t split_key(input logic [KEY_W-1:0] k);
    return key_fields_t'(k);
  endfunction

endpackage

// File: rtl/keypress_queue_if.sv
// Event stream handshake: head-of-queue key code with valid/ready.
interface keypress_queue_if;
  import wam_pkg::*;

  logic             evt_valid;
  logic [KEY_W-1:0] evt_key;
  logic             evt_ready;

  modport master (output evt_valid, output evt_key, input evt_ready);
  modport slave  (input evt_valid, input evt_key, output evt_ready);

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with flush; a push while full only lands if a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/keypress_queue.sv
// Synchronizes keypad key/valid, raises one event per new press or key change, and queues legal events.
module keypress_queue
  import wam_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int COORD_MAX = wam_pkg::COORD_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_key,
  input  logic [KEY_W-1:0]       key,
  input  logic                   flush,
  keypress_queue_if.master       evt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   bad_key
);

  typedef enum logic {IDLE, HELD} trk_state_e;

  localparam logic [1:0] CMAX = 2'(COORD_MAX);

  logic             valid_s1_q, valid_s2_q;
  logic [KEY_W-1:0] key_s1_q, key_s2_q;
  trk_state_e       state_q, state_d;
  logic [KEY_W-1:0] last_key_q, last_key_d;
  logic             overflow_q, overflow_d;
  logic             bad_key_q, bad_key_d;
  logic             raise, key_legal, push_req, pop_fire;
  logic             fifo_full, fifo_empty;
  key_fields_t      fields;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1_q <= 1'b0;
      valid_s2_q <= 1'b0;
      key_s1_q   <= '0;
      key_s2_q   <= '0;
    end else begin
      valid_s1_q <= valid_key;
      valid_s2_q <= valid_s1_q;
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
    end
  end

  // Latch on every raised event, legal or not, so a held illegal key is reported once.
  always_comb begin
    state_d    = state_q;
    last_key_d = last_key_q;
    raise      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_s2_q) begin
          state_d = HELD;
          raise   = 1'b1;
        end
      end
      HELD: begin
        if (!valid_s2_q)                   state_d = IDLE;
        else if (key_s2_q != last_key_q)   raise   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (raise) last_key_d = key_s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_key_q <= '0;
    end else begin
      state_q    <= state_d;
      last_key_q <= last_key_d;
    end
  end

  assign fields    = split_key(key_s2_q);
  assign key_legal = (fields.col <= CMAX) && (fields.row <= CMAX);
  assign push_req  = raise && key_legal && !flush;
  assign pop_fire  = evt.evt_ready && !fifo_empty;

  always_comb begin
    overflow_d = overflow_q;
    bad_key_d  = bad_key_q;
    if (flush) begin
      overflow_d = 1'b0;
      bad_key_d  = 1'b0;
    end else begin
      if (push_req && fifo_full && !pop_fire) overflow_d = 1'b1;
      if (raise && !key_legal)                bad_key_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      bad_key_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      bad_key_q  <= bad_key_d;
    end
  end

  sync_fifo #(
    .WIDTH(KEY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .push_i   (push_req),
    .wr_data_i(key_s2_q),
    .pop_i    (evt.evt_ready),
    .rd_data_o(evt.evt_key),
    .count_o  (count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign overflow      = overflow_q;
  assign bad_key       = bad_key_q;

endmodule

// File: tb/tb_keypress_queue.sv
// Directed and random stimulus for keypress_queue, checked against a queue-based reference model.
module tb_keypress_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_key;
  logic [3:0] key;
  logic       flush;
  logic [2:0] count;
  logic       overflow;
  logic       bad_key;

  keypress_queue_if evt_if ();

  keypress_queue #(.DEPTH(DEPTH), .COORD_MAX(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_key(valid_key),
    .key      (key),
    .flush    (flush),
    .evt      (evt_if),
    .count    (count),
    .overflow (overflow),
    .bad_key  (bad_key)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: synchronizer as a two-deep delay line of {valid,key} samples.
  logic [4:0] dl[$];
  logic [3:0] mq[$];
  logic       m_held, m_ovf, m_bad;
  logic [3:0] m_last;

  task automatic model_edge();
    logic [4:0] dec;
    logic       raise, legal, do_pop;
    if (reset) begin
      dl = '{5'd0, 5'd0};
      mq.delete();
      m_held = 1'b0;
      m_last = 4'd0;
      m_ovf  = 1'b0;
      m_bad  = 1'b0;
    end else begin
      dec = dl.pop_front();
      dl.push_back({valid_key, key});
      raise  = dec[4] && (!m_held || dec[3:0] != m_last);
      m_held = dec[4];
      if (raise) m_last = dec[3:0];
      legal  = (int'(dec[3:0]) / 4 <= 2) && (int'(dec[3:0]) % 4 <= 2);
      do_pop = (mq.size() > 0) && evt_if.evt_ready;
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
        m_bad = 1'b0;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (raise && legal) begin
          if (mq.size() < DEPTH) mq.push_back(dec[3:0]);
          else m_ovf = 1'b1;
        end
        if (raise && !legal) m_bad = 1'b1;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("evt_valid", {7'd0, evt_if.evt_valid}, {7'd0, mq.size() > 0});
    cmp("evt_key",   {4'd0, evt_if.evt_key}, (mq.size() > 0) ? {4'd0, mq[0]} : 8'd0);
    cmp("count",     {5'd0, count}, 8'(mq.size()));
    cmp("overflow",  {7'd0, overflow}, {7'd0, m_ovf});
    cmp("bad_key",   {7'd0, bad_key}, {7'd0, m_bad});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; valid_key = 1'b0; key = 4'd0; flush = 1'b0; evt_if.evt_ready = 1'b0;
    dl = '{5'd0, 5'd0};
    m_held = 1'b0; m_last = 4'd0; m_ovf = 1'b0; m_bad = 1'b0;
    ticks(2);
    cmp("reset_count", {5'd0, count}, 8'd0);

    // Single held key: event after the third posedge, and only one.
    reset = 1'b0; valid_key = 1'b1; key = 4'b0110;
    ticks(2);
    cmp("latency_pre", {7'd0, evt_if.evt_valid}, 8'd0);
    tick();
    cmp("latency_valid", {7'd0, evt_if.evt_valid}, 8'd1);
    cmp("latency_key", {4'd0, evt_if.evt_key}, 8'h06);
    ticks(17);
    cmp("held_once", {5'd0, count}, 8'd1);
    valid_key = 1'b0; evt_if.evt_ready = 1'b1;
    ticks(4);

    // Key change while held gives two ordered events.
    evt_if.evt_ready = 1'b0; valid_key = 1'b1; key = 4'b0000;
    ticks(5);
    key = 4'b1001;
    ticks(5);
    cmp("change_count", {5'd0, count}, 8'd2);
    cmp("change_head", {4'd0, evt_if.evt_key}, 8'h00);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    cmp("change_second", {4'd0, evt_if.evt_key}, 8'h09);
    valid_key = 1'b0; evt_if.evt_ready = 1'b1;
    ticks(3);

    // Five legal keys into a four-deep queue.
    evt_if.evt_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; valid_key = 1'b1;
    key = 4'd0; ticks(4);
    key = 4'd1; ticks(4);
    key = 4'd2; ticks(4);
    key = 4'd4; ticks(4);
    key = 4'd5; ticks(4);
    cmp("ovf_count", {5'd0, count}, 8'd4);
    cmp("ovf_flag", {7'd0, overflow}, 8'd1);
    cmp("ovf_head", {4'd0, evt_if.evt_key}, 8'h00);

    // Full queue: pop and push on the same edge.
    key = 4'd6; ticks(2);
    evt_if.evt_ready = 1'b1; tick();
    evt_if.evt_ready = 1'b0;
    cmp("fullpp_count", {5'd0, count}, 8'd4);
    cmp("fullpp_head", {4'd0, evt_if.evt_key}, 8'h01);
    evt_if.evt_ready = 1'b1; ticks(3);
    cmp("fullpp_tail", {4'd0, evt_if.evt_key}, 8'h06);
    ticks(2);

    // Illegal column, then flush.
    evt_if.evt_ready = 1'b0; key = 4'b1100;
    ticks(4);
    cmp("bad_flag", {7'd0, bad_key}, 8'd1);
    cmp("bad_count", {5'd0, count}, 8'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    cmp("bad_flush", {7'd0, bad_key}, 8'd0);

    // Reset mid-queue with key held.
    key = 4'd1; ticks(4);
    key = 4'd2; ticks(4);
    key = 4'd4; ticks(4);
    cmp("pre_reset_count", {5'd0, count}, 8'd3);
    reset = 1'b1; tick();
    cmp("rst_valid", {7'd0, evt_if.evt_valid}, 8'd0);
    cmp("rst_count", {5'd0, count}, 8'd0);
    reset = 1'b0; ticks(2);
    cmp("rst_reevent_pre", {7'd0, evt_if.evt_valid}, 8'd0);
    tick();
    cmp("rst_reevent", {7'd0, evt_if.evt_valid}, 8'd1);
    cmp("rst_reevent_key", {4'd0, evt_if.evt_key}, 8'h04);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) key = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) valid_key = ~valid_key;
      evt_if.evt_ready = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 150) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
